port_responder: RTL and testbench
=================================

Name: port_responder

Overview:
- Device-side responder for the CPU port bus: serves `get_enable`/`set_enable` cycles on `portaddr`/`portval` and returns data on `portout`.
- Replaces the simulation-only print/halt stub with synthesizable behaviour:
  - a halt latch;
  - a console output FIFO drained by an external consumer;
  - a console input FIFO filled by an external producer;
  - a status port and a scratch register.
- Sits between the CPU core port interface and the testbench/console model.

Parameters:
- WORD_SIZE, 16, width of port address and data words (matches parameters.v).
- FIFO_DEPTH, 4, entries in each console FIFO; power of two, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- portaddr  input  WORD_SIZE  port number for the current access.
- portval  input  WORD_SIZE  write data for a set access.
- get_enable  input  1  port read request, one-cycle strobe.
- set_enable  input  1  port write request, one-cycle strobe.
- portout  output  WORD_SIZE  registered read data.
- halted  output  1  machine-halt flag.
- out_data  output  WORD_SIZE  head of the output FIFO.
- out_valid  output  1  output FIFO non-empty.
- out_ready  input  1  consumer accepts `out_data`.
- in_data  input  WORD_SIZE  producer word.
- in_valid  input  1  producer word present.
- in_ready  output  1  input FIFO not full.

Behaviour:
- Reset (async, `reset_n`=0): `portout`=0, `halted`=0, both FIFOs empty, so `out_valid`=0 and `in_ready`=1. Sticky bits and the scratch register are cleared.
- Priority: `get_enable` takes priority over `set_enable`. If both are high, only the get is performed.
- Read latency: a get sampled at edge N loads `portout` at edge N, so the value is valid in cycle N+1. `portout` holds its value until the next get.
- Port map for get:
  - Port 0: returns 0.
  - Port 1: returns 0.
  - Port 2: pops the input FIFO and returns its head. If the FIFO is empty, returns 0 and sets sticky `underflow`.
  - Port 3: returns status. bit0 = out FIFO full, bit1 = in FIFO non-empty, bit2 = overflow, bit3 = underflow, bit4 = halted; other bits 0.
  - Port 4: returns scratch.
  - Other addresses: return 0.
- Port map for set:
  - Port 0: sets `halted`=1.
  - Port 1: pushes `portval` to the output FIFO. If the FIFO is full and no pop occurs in the same cycle, the word is dropped and sticky `overflow` is set.
  - Port 3: write-1-to-clear; `portval` bit2 clears overflow, bit3 clears underflow.
  - Port 4: loads scratch.
  - Other addresses: ignored.
- While `halted`=1: all sets are ignored. Gets are still served. `halted` is cleared only by reset.
- Output FIFO:
  - Pop when `out_valid` && `out_ready`.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
  - `out_data` is the head entry, combinational from storage.
- Input FIFO:
  - `in_ready` = not full.
  - Push when `in_valid` && `in_ready`.
  - A port-2 get and a push in the same cycle:
    - If the FIFO is non-empty, both occur.
    - If it is empty, the get returns 0 and sets underflow; the pushed word remains queued.
- Pointers: FIFO pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1, which distinguishes full from empty.
- Reset mid-operation: FIFO contents are discarded and all state returns to its reset value. `portout` is 0 in the first cycle after `reset_n` rises.

Decomposition:
- Shared package/include (parameters.v): WORD_SIZE and the port-number constants PORT_HALT=0, PORT_CONOUT=1, PORT_CONIN=2, PORT_STATUS=3, PORT_SCRATCH=4.
- Status bit-index constants STAT_OUT_FULL=0, STAT_IN_AVAIL=1, STAT_OVERFLOW=2, STAT_UNDERFLOW=3, STAT_HALTED=4 go in the same include.
- Sub-module `port_fifo`: a synchronous FIFO with async active-low reset.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, push_data, pop, head, full, empty.
  - Simultaneous push/pop is legal at any occupancy.
  - Instantiated twice.

Test Plan:
- Reset then idle: `portout`=0, `halted`=0, `out_valid`=0, `in_ready`=1. A get on port 3 returns 0x0000.
- Set port1 with 0x0041, 0x0042, `out_ready`=0: `out_valid`=1, `out_data`=0x0041. Raise `out_ready` for 2 cycles: consumer sees 0x0041 then 0x0042, then `out_valid`=0.
- Five sets on port1 with FIFO_DEPTH=4, `out_ready`=0: the fifth word is dropped and a port-3 get returns 0x0005 (full + overflow). A set on port3 with 0x0004 clears overflow, and a following get returns 0x0001.
- Producer pushes 0x1234 and a get on port2 follows: `portout`=0x1234 one cycle later. A second get on port2 returns 0 and a port-3 get shows bit3=1.
- Set port4 with 0xBEEF, then get port4: returns 0xBEEF. Same-cycle get port4 and set port4 with 0x1111: returns 0xBEEF and scratch is unchanged.
- Set port0 with any value: `halted`=1. A following set on port1 does not push (`out_valid` stays 0). Assert `reset_n`=0 mid-stream: all outputs return to reset values immediately.

Source files
------------

// File: rtl/port_responder_pkg.sv
// port_responder_pkg: shared constants for the port responder.
//   WORD_SIZE        default width of port addresses and data words
//   PORT_*           port numbers decoded by the responder
//   STAT_*           bit positions inside the status word (port 3)
package port_responder_pkg;

  localparam int WORD_SIZE = 16;

  localparam int PORT_HALT    = 0;
  localparam int PORT_CONOUT  = 1;
  localparam int PORT_CONIN   = 2;
  localparam int PORT_STATUS  = 3;
  localparam int PORT_SCRATCH = 4;

  localparam int STAT_OUT_FULL  = 0;
  localparam int STAT_IN_AVAIL  = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_UNDERFLOW = 3;
  localparam int STAT_HALTED    = 4;

endpackage

// File: rtl/port_fifo.sv
// port_fifo: synchronous FIFO, async active-low reset.
//   clk, reset_n      clock / reset
//   push, push_data   write strobe and data (ignored when full unless popping)
//   pop               read strobe (ignored when empty)
//   head              oldest entry, combinational from storage
//   full, empty       occupancy flags
// Push and pop in the same cycle are both honoured at any occupancy, so a
// full FIFO can accept a word while it is being drained.
module port_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointers wrap naturally at PW bits.
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/port_responder.sv
// port_responder: device side of the CPU port bus.
//   clk, reset_n              clock / async active-low reset
//   portaddr, portval         access address and write data
//   get_enable, set_enable    read / write strobes (get wins when both high)
//   portout                   registered read data, held until the next get
//   halted                    sticky halt flag, cleared only by reset
//   out_data/out_valid/out_ready   console output stream (FIFO head)
//   in_data/in_valid/in_ready      console input stream (FIFO tail)
module port_responder
  import port_responder_pkg::*;
#(
  parameter int WORD_SIZE  = port_responder_pkg::WORD_SIZE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] portaddr,
  input  logic [WORD_SIZE-1:0] portval,
  input  logic                 get_enable,
  input  logic                 set_enable,
  output logic [WORD_SIZE-1:0] portout,
  output logic                 halted,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready
);

  logic [WORD_SIZE-1:0] portout_q, portout_d;
  logic [WORD_SIZE-1:0] scratch_q, scratch_d;
  logic                 halted_q, halted_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;

  logic                 get_act, set_act;
  logic                 out_push, out_pop, out_full, out_empty;
  logic                 in_push, in_pop, in_full, in_empty;
  logic [WORD_SIZE-1:0] in_head;
  logic [WORD_SIZE-1:0] status;
  logic [WORD_SIZE-1:0] rd_data;

  function automatic logic is_port(input logic [WORD_SIZE-1:0] a, input int p);
    return a == WORD_SIZE'(p);
  endfunction

  // Get has priority; a halted machine ignores every set.
  assign get_act = get_enable;
  assign set_act = set_enable && !get_enable && !halted_q;

  assign out_pop  = !out_empty && out_ready;
  assign out_push = set_act && is_port(portaddr, PORT_CONOUT);

  assign in_push = in_valid && !in_full;
  assign in_pop  = get_act && is_port(portaddr, PORT_CONIN) && !in_empty;

  port_fifo #(.WIDTH(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (out_push),
    .push_data (portval),
    .pop       (out_pop),
    .head      (out_data),
    .full      (out_full),
    .empty     (out_empty)
  );

  port_fifo #(.WIDTH(WORD_SIZE), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_push),
    .push_data (in_data),
    .pop       (in_pop),
    .head      (in_head),
    .full      (in_full),
    .empty     (in_empty)
  );

  always_comb begin
    status                 = '0;
    status[STAT_OUT_FULL]  = out_full;
    status[STAT_IN_AVAIL]  = !in_empty;
    status[STAT_OVERFLOW]  = overflow_q;
    status[STAT_UNDERFLOW] = underflow_q;
    status[STAT_HALTED]    = halted_q;
  end

  always_comb begin
    rd_data = '0;
    if (is_port(portaddr, PORT_CONIN) && !in_empty) rd_data = in_head;
    else if (is_port(portaddr, PORT_STATUS))        rd_data = status;
    else if (is_port(portaddr, PORT_SCRATCH))       rd_data = scratch_q;
  end

  always_comb begin
    portout_d   = portout_q;
    scratch_d   = scratch_q;
    halted_d    = halted_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (get_act) begin
      portout_d = rd_data;
      if (is_port(portaddr, PORT_CONIN) && in_empty) underflow_d = 1'b1;
    end

    if (set_act) begin
      if (is_port(portaddr, PORT_HALT)) halted_d = 1'b1;
      // A full FIFO still accepts the word if the consumer pops this cycle.
      if (is_port(portaddr, PORT_CONOUT) && out_full && !out_pop) overflow_d = 1'b1;
      if (is_port(portaddr, PORT_STATUS)) begin
        if (portval[STAT_OVERFLOW])  overflow_d  = 1'b0;
        if (portval[STAT_UNDERFLOW]) underflow_d = 1'b0;
      end
      if (is_port(portaddr, PORT_SCRATCH)) scratch_d = portval;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      portout_q   <= '0;
      scratch_q   <= '0;
      halted_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      portout_q   <= portout_d;
      scratch_q   <= scratch_d;
      halted_q    <= halted_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign portout   = portout_q;
  assign halted    = halted_q;
  assign out_valid = !out_empty;
  assign in_ready  = !in_full;

endmodule

// File: tb/tb_port_responder.sv
module tb_port_responder;

  logic        clk;
  logic        reset_n;
  logic [15:0] portaddr;
  logic [15:0] portval;
  logic        get_enable;
  logic        set_enable;
  logic [15:0] portout;
  logic        halted;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;

  int checks = 0;
  int errors = 0;

  port_responder #(.WORD_SIZE(16), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .portaddr   (portaddr),
    .portval    (portval),
    .get_enable (get_enable),
    .set_enable (set_enable),
    .portout    (portout),
    .halted     (halted),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_get(input logic [15:0] a);
    portaddr = a; get_enable = 1'b1;
    tick();
    get_enable = 1'b0;
  endtask

  task automatic do_set(input logic [15:0] a, input logic [15:0] v);
    portaddr = a; portval = v; set_enable = 1'b1;
    tick();
    set_enable = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; portaddr = '0; portval = '0; get_enable = 1'b0;
    set_enable = 1'b0; out_ready = 1'b0; in_data = '0; in_valid = 1'b0;
    #12;
    check("rst_portout", portout, 16'h0000);
    check("rst_halted", {15'd0, halted}, 16'h0000);
    check("rst_out_valid", {15'd0, out_valid}, 16'h0000);
    check("rst_in_ready", {15'd0, in_ready}, 16'h0001);
    reset_n = 1'b1;
    tick();

    do_get(16'd3);
    check("idle_status", portout, 16'h0000);

    // Console output: two words, then drain
    do_set(16'd1, 16'h0041);
    do_set(16'd1, 16'h0042);
    check("out_valid_after_push", {15'd0, out_valid}, 16'h0001);
    check("out_head_first", out_data, 16'h0041);
    out_ready = 1'b1;
    tick();
    check("out_head_second", out_data, 16'h0042);
    tick();
    out_ready = 1'b0;
    check("out_drained", {15'd0, out_valid}, 16'h0000);

    // Overflow: five pushes into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) do_set(16'd1, 16'(i));
    do_get(16'd3);
    check("status_full_ovf", portout, 16'h0005);
    do_set(16'd3, 16'h0004);
    do_get(16'd3);
    check("status_ovf_cleared", portout, 16'h0001);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("ovf_drain_order", out_data, 16'(i));
      tick();
    end
    out_ready = 1'b0;
    check("ovf_drain_empty", {15'd0, out_valid}, 16'h0000);

    // Input FIFO: push then get, then underflow
    in_data = 16'h1234; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    do_get(16'd2);
    check("conin_word", portout, 16'h1234);
    do_get(16'd2);
    check("conin_empty_zero", portout, 16'h0000);
    do_get(16'd3);
    check("status_underflow", portout, 16'h0008);
    do_set(16'd3, 16'h0008);

    // Get on empty input FIFO with a push in the same cycle
    portaddr = 16'd2; get_enable = 1'b1; in_data = 16'h0055; in_valid = 1'b1;
    tick();
    get_enable = 1'b0; in_valid = 1'b0;
    check("conin_race_zero", portout, 16'h0000);
    do_get(16'd3);
    check("status_race", portout, 16'h000A);
    do_get(16'd2);
    check("conin_race_kept", portout, 16'h0055);
    do_set(16'd3, 16'h0008);
    do_get(16'd3);
    check("status_unf_cleared", portout, 16'h0000);

    // Input FIFO full
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 16'h00A0 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    check("in_full_not_ready", {15'd0, in_ready}, 16'h0000);
    do_get(16'd3);
    check("status_in_avail", portout, 16'h0002);
    for (int i = 0; i < 4; i++) begin
      do_get(16'd2);
      check("conin_order", portout, 16'h00A0 + 16'(i));
    end
    check("in_ready_again", {15'd0, in_ready}, 16'h0001);

    // Scratch and get/set priority
    do_set(16'd4, 16'hBEEF);
    do_get(16'd4);
    check("scratch_read", portout, 16'hBEEF);
    portaddr = 16'd4; portval = 16'h1111; get_enable = 1'b1; set_enable = 1'b1;
    tick();
    get_enable = 1'b0; set_enable = 1'b0;
    check("prio_get_value", portout, 16'hBEEF);
    do_get(16'd4);
    check("prio_scratch_kept", portout, 16'hBEEF);
    do_get(16'd7);
    check("unmapped_zero", portout, 16'h0000);

    // Halt
    do_set(16'd0, 16'h00FF);
    check("halted_set", {15'd0, halted}, 16'h0001);
    do_set(16'd1, 16'h0077);
    check("halt_no_push", {15'd0, out_valid}, 16'h0000);
    do_set(16'd4, 16'h2222);
    do_get(16'd4);
    check("halt_scratch_kept", portout, 16'hBEEF);
    do_get(16'd3);
    check("status_halted", portout, 16'h0010);
    in_data = 16'h0099; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;

    // Reset mid-stream
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_portout", portout, 16'h0000);
    check("mid_rst_halted", {15'd0, halted}, 16'h0000);
    check("mid_rst_in_ready", {15'd0, in_ready}, 16'h0001);
    check("mid_rst_out_valid", {15'd0, out_valid}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_rst_portout", portout, 16'h0000);
    do_get(16'd3);
    check("post_rst_status", portout, 16'h0000);
    do_get(16'd4);
    check("post_rst_scratch", portout, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
